// File: rtl/gemm_sequencer.sv
// GEMM compute sequencer: accepts one instruction, pops dependency tokens,
// issues it to the GEMM datapath for the computed length, drains, pushes tokens.
module gemm_sequencer #(
   parameter int INS_WIDTH  = 128,
   parameter int PIPE_DEPTH = 4,
   parameter int LEN_WIDTH  = 42
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INS_WIDTH-1:0] insn_in,
   input  logic                 insn_valid,
   output logic                 insn_ready,
   input  logic                 l2c_dep_valid,
   output logic                 l2c_dep_ready,
   input  logic                 s2c_dep_valid,
   output logic                 s2c_dep_ready,
   output logic                 c2l_dep_valid,
   input  logic                 c2l_dep_ready,
   output logic                 c2s_dep_valid,
   input  logic                 c2s_dep_ready,
   output logic [INS_WIDTH-1:0] gemm_insn,
   output logic                 busy,
   output logic                 done,
   output logic                 finish
);

   // state    | meaning
   // IDLE     | waiting for an instruction, insn_ready high
   // WAIT_DEP | popping the l2c / s2c tokens the instruction asks for
   // ISSUE    | driving gemm_insn for issue_len cycles
   // DRAIN    | letting the datapath pipeline empty (PIPE_DEPTH cycles)
   // PUSH     | pushing c2l / c2s tokens, then done (and finish) pulse
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_DEP = 3'd1,
      ISSUE    = 3'd2,
      DRAIN    = 3'd3,
      PUSH     = 3'd4
   } state_t;

   localparam logic [2:0] OP_GEMM   = 3'b010;
   localparam logic [2:0] OP_FINISH = 3'b011;

   state_t                 state, state_nxt;
   logic [INS_WIDTH-1:0]   insn_reg;
   logic [LEN_WIDTH-1:0]   cnt, cnt_nxt;
   logic                   got_l2c, got_l2c_nxt;
   logic                   got_s2c, got_s2c_nxt;
   logic                   put_c2l, put_c2l_nxt;
   logic                   put_c2s, put_c2s_nxt;

   logic [2:0]             opcode;
   logic                   pop_prev, pop_next, push_prev, push_next;
   logic [13:0]            uop_bgn, uop_end, iter_out, iter_in, uop_span;
   logic [LEN_WIDTH-1:0]   issue_len;

   assign opcode    = insn_reg[2:0];
   assign pop_prev  = insn_reg[3];
   assign pop_next  = insn_reg[4];
   assign push_prev = insn_reg[5];
   assign push_next = insn_reg[6];
   assign uop_bgn   = {1'b0, insn_reg[20:8]};
   assign uop_end   = insn_reg[34:21];
   assign iter_out  = insn_reg[48:35];
   assign iter_in   = insn_reg[62:49];
   assign uop_span  = uop_end - uop_bgn;

   // An empty or inverted uop range means nothing to issue.
   assign issue_len = (uop_end > uop_bgn) ?
                      LEN_WIDTH'(iter_out) * LEN_WIDTH'(iter_in) * LEN_WIDTH'(uop_span) :
                      '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         insn_reg <= '0;
         cnt      <= '0;
         got_l2c  <= 1'b0;
         got_s2c  <= 1'b0;
         put_c2l  <= 1'b0;
         put_c2s  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         got_l2c <= got_l2c_nxt;
         got_s2c <= got_s2c_nxt;
         put_c2l <= put_c2l_nxt;
         put_c2s <= put_c2s_nxt;
         if (state == IDLE && insn_valid)
            insn_reg <= insn_in;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      got_l2c_nxt   = got_l2c;
      got_s2c_nxt   = got_s2c;
      put_c2l_nxt   = put_c2l;
      put_c2s_nxt   = put_c2s;
      insn_ready    = 1'b0;
      l2c_dep_ready = 1'b0;
      s2c_dep_ready = 1'b0;
      c2l_dep_valid = 1'b0;
      c2s_dep_valid = 1'b0;
      gemm_insn     = '0;
      done          = 1'b0;
      finish        = 1'b0;
      busy          = (state != IDLE);

      case (state)
         IDLE: begin
            insn_ready = 1'b1;
            if (insn_valid) begin
               state_nxt   = WAIT_DEP;
               got_l2c_nxt = 1'b0;
               got_s2c_nxt = 1'b0;
               put_c2l_nxt = 1'b0;
               put_c2s_nxt = 1'b0;
            end
         end

         WAIT_DEP: begin
            l2c_dep_ready = pop_prev && !got_l2c;
            s2c_dep_ready = pop_next && !got_s2c;
            got_l2c_nxt   = got_l2c || (pop_prev && !got_l2c && l2c_dep_valid);
            got_s2c_nxt   = got_s2c || (pop_next && !got_s2c && s2c_dep_valid);
            // A token consumed this cycle already counts, so issue follows the pop directly.
            if ((!pop_prev || got_l2c_nxt) && (!pop_next || got_s2c_nxt)) begin
               if (opcode == OP_GEMM && issue_len != '0) begin
                  state_nxt = ISSUE;
                  cnt_nxt   = issue_len;
               end else begin
                  state_nxt = PUSH;
               end
            end
         end

         ISSUE: begin
            gemm_insn = insn_reg;
            if (cnt == LEN_WIDTH'(1)) begin
               if (PIPE_DEPTH == 0) begin
                  state_nxt = PUSH;
               end else begin
                  state_nxt = DRAIN;
                  cnt_nxt   = LEN_WIDTH'(PIPE_DEPTH);
               end
            end else begin
               cnt_nxt = cnt - LEN_WIDTH'(1);
            end
         end

         DRAIN: begin
            if (cnt == LEN_WIDTH'(1))
               state_nxt = PUSH;
            else
               cnt_nxt = cnt - LEN_WIDTH'(1);
         end

         PUSH: begin
            c2l_dep_valid = push_prev && !put_c2l;
            c2s_dep_valid = push_next && !put_c2s;
            if (push_prev && !put_c2l && c2l_dep_ready)
               put_c2l_nxt = 1'b1;
            if (push_next && !put_c2s && c2s_dep_ready)
               put_c2s_nxt = 1'b1;
            // Completion is taken from the registered flags: done lands the cycle after the last push.
            if ((!push_prev || put_c2l) && (!push_next || put_c2s)) begin
               state_nxt = IDLE;
               done      = 1'b1;
               finish    = (opcode == OP_FINISH);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gemm_sequencer.sv
// Directed self-checking bench for gemm_sequencer: issue timing, token
// pops/pushes, finish opcode and asynchronous reset mid-issue.
module tb_gemm_sequencer;

   logic         clk;
   logic         rst;
   logic [127:0] insn_in;
   logic         insn_valid;
   logic         insn_ready;
   logic         l2c_dep_valid, l2c_dep_ready;
   logic         s2c_dep_valid, s2c_dep_ready;
   logic         c2l_dep_valid, c2l_dep_ready;
   logic         c2s_dep_valid, c2s_dep_ready;
   logic [127:0] gemm_insn;
   logic         busy, done, finish;

   int n_chk = 0;
   int n_bad = 0;

   gemm_sequencer #(.INS_WIDTH(128), .PIPE_DEPTH(4), .LEN_WIDTH(42)) dut (
      .clk           (clk),
      .rst           (rst),
      .insn_in       (insn_in),
      .insn_valid    (insn_valid),
      .insn_ready    (insn_ready),
      .l2c_dep_valid (l2c_dep_valid),
      .l2c_dep_ready (l2c_dep_ready),
      .s2c_dep_valid (s2c_dep_valid),
      .s2c_dep_ready (s2c_dep_ready),
      .c2l_dep_valid (c2l_dep_valid),
      .c2l_dep_ready (c2l_dep_ready),
      .c2s_dep_valid (c2s_dep_valid),
      .c2s_dep_ready (c2s_dep_ready),
      .gemm_insn     (gemm_insn),
      .busy          (busy),
      .done          (done),
      .finish        (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ctl_vec();
      return {insn_ready, l2c_dep_ready, s2c_dep_ready, c2l_dep_valid,
              c2s_dep_valid, busy, done, finish};
   endfunction

   function automatic logic [127:0] mk(input logic [2:0] op, input logic pp, input logic pn,
                                       input logic qp, input logic qn, input logic [12:0] ub,
                                       input logic [13:0] ue, input logic [13:0] io,
                                       input logic [13:0] ii);
      logic [127:0] r;
      r         = '0;
      r[127:64] = 64'hC0DE_5A5A_0F0F_1234;
      r[2:0]    = op;
      r[3]      = pp;
      r[4]      = pn;
      r[5]      = qp;
      r[6]      = qn;
      r[20:8]   = ub;
      r[34:21]  = ue;
      r[48:35]  = io;
      r[62:49]  = ii;
      return r;
   endfunction

   // Handshake one instruction; returns with the DUT sampled in its first WAIT_DEP cycle.
   task automatic send(input string tag, input logic [127:0] ins);
      chk({tag, "_rdy"}, insn_ready, 1'b1);
      insn_in    = ins;
      insn_valid = 1'b1;
      tick();
      insn_valid = 1'b0;
      insn_in    = {4{32'hDEAD_BEEF}};
      chk({tag, "_busy"}, busy, 1'b1);
   endtask

   // Samples the current cycle as c=0 and steps until done or the budget runs out.
   task automatic run_to_done(input logic [127:0] ins, input int max_c,
                              output int n_iss, output int first_iss, output int last_iss,
                              output int n_junk, output int done_c, output logic fin,
                              output logic rdy_at_done);
      n_iss = 0; first_iss = -1; last_iss = -1; n_junk = 0;
      done_c = -1; fin = 1'b0; rdy_at_done = 1'b1;
      for (int c = 0; c < max_c; c++) begin
         if (gemm_insn === ins) begin
            if (first_iss < 0) first_iss = c;
            last_iss = c;
            n_iss++;
         end else if (gemm_insn !== '0) begin
            n_junk++;
         end
         if (done === 1'b1) begin
            done_c      = c;
            fin         = finish;
            rdy_at_done = insn_ready;
            break;
         end
         tick();
      end
   endtask

   initial begin
      logic [127:0] ins;
      int n_iss, first_iss, last_iss, n_junk, done_c, cnt_a, cnt_b;
      logic fin, rdy;

      rst = 1'b0;
      insn_in = '0; insn_valid = 1'b0;
      l2c_dep_valid = 1'b0; s2c_dep_valid = 1'b0;
      c2l_dep_ready = 1'b0; c2s_dep_ready = 1'b0;
      #23;
      chk("rst_ctl", ctl_vec(), 8'b1000_0000);
      chk("rst_gemm", gemm_insn, '0);
      rst = 1'b1;
      tick();

      // GEMM 2x3x4 = 24 issue cycles, 4 drain, done in PUSH, ready one cycle later
      ins = mk(3'b010, 0, 0, 0, 0, 13'd0, 14'd4, 14'd2, 14'd3);
      send("g24", ins);
      chk("g24_wait_zero", gemm_insn, '0);
      run_to_done(ins, 60, n_iss, first_iss, last_iss, n_junk, done_c, fin, rdy);
      chk("g24_n_issue", n_iss, 24);
      chk("g24_first", first_iss, 1);
      chk("g24_last", last_iss, 24);
      chk("g24_junk", n_junk, 0);
      chk("g24_done_at", done_c, 29);
      chk("g24_fin", fin, 1'b0);
      chk("g24_rdy_at_done", rdy, 1'b0);
      tick();
      chk("g24_after", ctl_vec(), 8'b1000_0000);

      // pop_prev held off for 10 cycles, then issue length 2 right after valid
      ins = mk(3'b010, 1, 0, 0, 0, 13'd3, 14'd5, 14'd1, 14'd1);
      send("pp", ins);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         if (gemm_insn !== '0) cnt_a++;
         if (l2c_dep_ready !== 1'b1 || s2c_dep_ready !== 1'b0) cnt_b++;
         tick();
      end
      chk("pp_hold_gemm", cnt_a, 0);
      chk("pp_hold_ready", cnt_b, 0);
      l2c_dep_valid = 1'b1;
      chk("pp_ready_at_valid", l2c_dep_ready, 1'b1);
      tick();
      l2c_dep_valid = 1'b0;
      chk("pp_issue_start", gemm_insn, ins);
      chk("pp_ready_off", l2c_dep_ready, 1'b0);
      run_to_done(ins, 30, n_iss, first_iss, last_iss, n_junk, done_c, fin, rdy);
      chk("pp_n_issue", n_iss, 2);
      chk("pp_done_at", done_c, 6);
      tick();

      // iter_in=0 with push_next: no issue, c2s valid holds through 5 stalled cycles
      ins = mk(3'b010, 0, 0, 0, 1, 13'd0, 14'd8, 14'd5, 14'd0);
      send("pn", ins);
      chk("pn_wait_zero", gemm_insn, '0);
      tick();
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         if (ctl_vec() !== 8'b0000_1100 || gemm_insn !== '0) cnt_a++;
         tick();
      end
      chk("pn_stall", cnt_a, 0);
      c2s_dep_ready = 1'b1;
      chk("pn_fire_ctl", ctl_vec(), 8'b0000_1100);
      tick();
      c2s_dep_ready = 1'b0;
      chk("pn_done_ctl", ctl_vec(), 8'b0000_0110);
      tick();
      chk("pn_idle", ctl_vec(), 8'b1000_0000);

      // both pushes complete in the same cycle, done follows next cycle
      ins = mk(3'b000, 0, 0, 1, 1, 13'd0, 14'd1, 14'd1, 14'd1);
      send("pb", ins);
      tick();
      c2l_dep_ready = 1'b1;
      c2s_dep_ready = 1'b1;
      chk("pb_fire_ctl", ctl_vec(), 8'b0001_1100);
      tick();
      c2l_dep_ready = 1'b0;
      c2s_dep_ready = 1'b0;
      chk("pb_done_ctl", ctl_vec(), 8'b0000_0110);
      chk("pb_gemm", gemm_insn, '0);
      tick();
      chk("pb_idle", ctl_vec(), 8'b1000_0000);

      // FINISH opcode: no issue, done and finish together for one cycle
      ins = mk(3'b011, 0, 0, 0, 0, 13'd0, 14'd4, 14'd2, 14'd3);
      send("fin", ins);
      run_to_done(ins, 20, n_iss, first_iss, last_iss, n_junk, done_c, fin, rdy);
      chk("fin_n_issue", n_iss + n_junk, 0);
      chk("fin_done_at", done_c, 1);
      chk("fin_flag", fin, 1'b1);
      tick();
      chk("fin_pulse_end", ctl_vec(), 8'b1000_0000);

      // async reset during the 5th issue cycle; nothing completes afterwards
      ins = mk(3'b010, 0, 0, 1, 1, 13'd0, 14'd4, 14'd2, 14'd3);
      send("rs", ins);
      for (int i = 0; i < 5; i++) tick();
      chk("rs_issuing", gemm_insn, ins);
      #2;
      rst = 1'b0;
      #1;
      chk("rs_async_ctl", ctl_vec(), 8'b1000_0000);
      chk("rs_async_gemm", gemm_insn, '0);
      tick();
      tick();
      #2;
      rst = 1'b1;
      tick();
      cnt_a = 0;
      for (int i = 0; i < 40; i++) begin
         if (ctl_vec() !== 8'b1000_0000 || gemm_insn !== '0) cnt_a++;
         tick();
      end
      chk("rs_quiet", cnt_a, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
